// File: rtl/image_stream_engine.sv
// Streaming RGB888 point-operation engine with VSYNC/HSYNC timing and line/frame markers.
// Optional build macro IMAGE_GRAY_MODE_EN adds a gray_en port selecting a luma conversion.
module image_stream_engine #(
  parameter int WIDTH         = 768,
  parameter int HEIGHT        = 512,
  parameter int PPC           = 2,
  parameter int STARTUP_DELAY = 100,
  parameter int HSYNC_DELAY   = 160
) (
  input  logic               HCLK,
  input  logic               HRESET,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic               sign,
  input  logic [7:0]         bright_val,
  input  logic [7:0]         thresh_val,
`ifdef IMAGE_GRAY_MODE_EN
  input  logic               gray_en,
`endif
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [24*PPC-1:0]  in_data,
  output logic               VSYNC,
  output logic               HSYNC,
  output logic               out_valid,
  output logic [24*PPC-1:0]  out_data,
  output logic               out_eol,
  output logic               out_eof,
  output logic               ctrl_done,
  output logic [15:0]        underflow_cnt
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam int RW = $clog2(HEIGHT + 1);
  localparam int DMAX = (STARTUP_DELAY > HSYNC_DELAY) ? STARTUP_DELAY : HSYNC_DELAY;
  localparam int DW = $clog2(DMAX + 1);
  localparam logic [CW-1:0] COL_LAST = CW'(WIDTH - PPC);
  localparam logic [CW-1:0] COL_STEP = CW'(PPC);
  localparam logic [RW-1:0] ROW_LAST = RW'(HEIGHT - 1);
  localparam logic [DW-1:0] V_LAST   = DW'(STARTUP_DELAY - 1);
  localparam logic [DW-1:0] H_LAST   = DW'(HSYNC_DELAY - 1);

  typedef enum logic [2:0] {S_IDLE, S_VBLANK, S_HBLANK, S_ACTIVE, S_DONE} state_t;

  state_t            state_reg, state_next;
  logic [DW-1:0]     dly_reg, dly_next;
  logic [CW-1:0]     col_reg, col_next;
  logic [RW-1:0]     row_reg, row_next;
  logic [15:0]       under_reg, under_next;
  logic              accept, cfg_load, eol_next, eof_next;
  logic [1:0]        cfg_mode_reg;
  logic              cfg_sign_reg;
  logic [7:0]        cfg_bright_reg, cfg_thresh_reg;
  logic              gray_sel;
  logic              vsync_reg, hsync_reg, in_ready_reg, ctrl_done_reg;
  logic              out_valid_reg, out_eol_reg, out_eof_reg;
  logic [24*PPC-1:0] out_data_reg, proc_data;

`ifdef IMAGE_GRAY_MODE_EN
  logic cfg_gray_reg;
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET)       cfg_gray_reg <= 1'b0;
    else if (cfg_load) cfg_gray_reg <= gray_en;
  end
  assign gray_sel = cfg_gray_reg;
`else
  assign gray_sel = 1'b0;
`endif

  always_comb begin
    state_next = state_reg;
    dly_next   = dly_reg;
    col_next   = col_reg;
    row_next   = row_reg;
    under_next = under_reg;
    accept     = 1'b0;
    cfg_load   = 1'b0;
    eol_next   = 1'b0;
    eof_next   = 1'b0;
    case (state_reg)
      S_IDLE: if (start) begin
        cfg_load   = 1'b1;
        under_next = '0;
        dly_next   = '0;
        state_next = S_VBLANK;
      end
      S_VBLANK: if (dly_reg == V_LAST) begin
        dly_next   = '0;
        state_next = S_HBLANK;
      end else dly_next = dly_reg + 1'b1;
      S_HBLANK: if (dly_reg == H_LAST) begin
        dly_next   = '0;
        state_next = S_ACTIVE;
      end else dly_next = dly_reg + 1'b1;
      S_ACTIVE: if (in_valid) begin
        accept = 1'b1;
        if (col_reg == COL_LAST) begin
          col_next = '0;
          eol_next = 1'b1;
          if (row_reg == ROW_LAST) begin
            row_next   = '0;
            eof_next   = 1'b1;
            state_next = S_DONE;
          end else begin
            row_next   = row_reg + 1'b1;
            state_next = S_HBLANK;
          end
        end else col_next = col_reg + COL_STEP;
      end else if (under_reg != 16'hFFFF) under_next = under_reg + 1'b1;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Saturating add / floor-at-zero subtract at 9 bits, or invert; threshold handled per pixel.
  function automatic logic [7:0] chan_op(input logic [7:0] x, input logic [1:0] m,
                                         input logic s, input logic [7:0] b);
    logic [8:0] sum9;
    logic [8:0] diff9;
    sum9  = {1'b0, x} + {1'b0, b};
    diff9 = {1'b0, x} - {1'b0, b};
    case (m)
      2'b01:   chan_op = s ? (sum9[8] ? 8'hFF : sum9[7:0]) : (diff9[8] ? 8'h00 : diff9[7:0]);
      2'b10:   chan_op = 8'hFF - x;
      default: chan_op = x;
    endcase
  endfunction

  genvar gi;
  generate
    for (gi = 0; gi < PPC; gi++) begin : g_pix
      logic [7:0]  r, g, b, y;
      logic [9:0]  sum, thr3;
      logic [15:0] luma;
      assign r    = in_data[24*gi+16 +: 8];
      assign g    = in_data[24*gi+8  +: 8];
      assign b    = in_data[24*gi    +: 8];
      assign sum  = {2'b00, r} + {2'b00, g} + {2'b00, b};
      assign thr3 = {2'b00, cfg_thresh_reg} + {1'b0, cfg_thresh_reg, 1'b0};
      assign luma = 16'd77 * {8'd0, r} + 16'd150 * {8'd0, g} + 16'd29 * {8'd0, b};
      assign y    = (sum > thr3) ? 8'hFF : 8'h00;
      always_comb begin
        proc_data[24*gi +: 24] = {chan_op(r, cfg_mode_reg, cfg_sign_reg, cfg_bright_reg),
                                  chan_op(g, cfg_mode_reg, cfg_sign_reg, cfg_bright_reg),
                                  chan_op(b, cfg_mode_reg, cfg_sign_reg, cfg_bright_reg)};
        if (gray_sel)                   proc_data[24*gi +: 24] = {3{luma[15:8]}};
        else if (cfg_mode_reg == 2'b11) proc_data[24*gi +: 24] = {3{y}};
      end
    end
  endgenerate

  // Sync/ready/done flags are registered from the next state so they track the FSM exactly.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      state_reg      <= S_IDLE;
      dly_reg        <= '0;
      col_reg        <= '0;
      row_reg        <= '0;
      under_reg      <= '0;
      cfg_mode_reg   <= '0;
      cfg_sign_reg   <= 1'b0;
      cfg_bright_reg <= '0;
      cfg_thresh_reg <= '0;
      vsync_reg      <= 1'b0;
      hsync_reg      <= 1'b0;
      in_ready_reg   <= 1'b0;
      ctrl_done_reg  <= 1'b0;
      out_valid_reg  <= 1'b0;
      out_eol_reg    <= 1'b0;
      out_eof_reg    <= 1'b0;
      out_data_reg   <= '0;
    end else begin
      state_reg     <= state_next;
      dly_reg       <= dly_next;
      col_reg       <= col_next;
      row_reg       <= row_next;
      under_reg     <= under_next;
      vsync_reg     <= (state_next == S_VBLANK);
      hsync_reg     <= (state_next == S_HBLANK);
      in_ready_reg  <= (state_next == S_ACTIVE);
      ctrl_done_reg <= (state_next == S_DONE);
      out_valid_reg <= accept;
      out_eol_reg   <= eol_next;
      out_eof_reg   <= eof_next;
      if (accept) out_data_reg <= proc_data;
      if (cfg_load) begin
        cfg_mode_reg   <= mode;
        cfg_sign_reg   <= sign;
        cfg_bright_reg <= bright_val;
        cfg_thresh_reg <= thresh_val;
      end
    end
  end

  assign VSYNC         = vsync_reg;
  assign HSYNC         = hsync_reg;
  assign in_ready      = in_ready_reg;
  assign ctrl_done     = ctrl_done_reg;
  assign out_valid     = out_valid_reg;
  assign out_eol       = out_eol_reg;
  assign out_eof       = out_eof_reg;
  assign out_data      = out_data_reg;
  assign underflow_cnt = under_reg;

endmodule

// File: tb/tb_image_stream_engine.sv
// Directed bench for image_stream_engine: 8x2 frames, PPC=2, short blanking.
module tb_image_stream_engine;
  localparam int W = 8, H = 2, P = 2, SD = 3, HD = 2;
  localparam int NB = (W / P) * H;

  logic          HCLK = 1'b0;
  logic          HRESET = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          sign = 1'b0;
  logic [7:0]    bright_val = 8'd0;
  logic [7:0]    thresh_val = 8'd0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [47:0]   in_data = '0;
  logic          VSYNC, HSYNC, out_valid, out_eol, out_eof, ctrl_done;
  logic [47:0]   out_data;
  logic [15:0]   underflow_cnt;

  int checks = 0;
  int errors = 0;
  int frame_id = 0;

  logic [47:0] in_beats  [NB];
  logic [47:0] exp_beats [NB];

  typedef struct {
    logic [1:0]  mode;
    logic        sign;
    logic [7:0]  bright;
    logic [7:0]  thresh;
    logic [47:0] din;
    logic [47:0] dexp;
  } vec_t;
  vec_t vecs [9];

  always #5 HCLK = ~HCLK;

  image_stream_engine #(.WIDTH(W), .HEIGHT(H), .PPC(P), .STARTUP_DELAY(SD), .HSYNC_DELAY(HD)) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start), .mode(mode), .sign(sign),
    .bright_val(bright_val), .thresh_val(thresh_val), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .VSYNC(VSYNC), .HSYNC(HSYNC), .out_valid(out_valid), .out_data(out_data),
    .out_eol(out_eol), .out_eof(out_eof), .ctrl_done(ctrl_done), .underflow_cnt(underflow_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s (frame %0d): got %0h, expected %0h", name, frame_id, act, req);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_ctrl"}, {VSYNC, HSYNC, in_ready, out_valid, out_eol, out_eof, ctrl_done, underflow_cnt}, 64'd0);
    check({name, "_data"}, out_data, 64'd0);
  endtask

  task automatic fill_distinct(input logic [7:0] seed);
    for (int k = 0; k < NB; k++) begin
      logic [7:0] bk;
      bk = seed + 8'(k);
      in_beats[k]  = {bk, 8'hA0, bk ^ 8'h3C, ~bk, 8'h11, bk + 8'h40};
      exp_beats[k] = in_beats[k];
    end
  endtask

  // Runs one frame; config ports are scrambled right after start to prove they were sampled.
  task automatic run_frame(input logic [1:0] m, input logic s, input logic [7:0] b, input logic [7:0] t,
                           input int stall_beat, input int stall_len, input bit start_mid);
    int idx, out_cnt, vs, hs, gaps, dones, cyc, stall_rem, bad_marks, ir_bad, extra;
    bit first_seen, done_seen;
    idx = 0; out_cnt = 0; vs = 0; hs = 0; gaps = 0; dones = 0; cyc = 0;
    stall_rem = stall_len; bad_marks = 0; ir_bad = 0; extra = 0;
    first_seen = 0; done_seen = 0;
    frame_id++;
    in_valid = 1'b1;
    start = 1'b1; mode = m; sign = s; bright_val = b; thresh_val = t;
    step();
    start = 1'b0;
    mode = m ^ 2'b11; sign = ~s; bright_val = b ^ 8'h5A; thresh_val = t ^ 8'hA5;
    while (!done_seen && cyc < 300) begin
      if (VSYNC) vs++;
      if (HSYNC) hs++;
      if ((out_eol || out_eof) && !out_valid) bad_marks++;
      if (out_valid) begin
        first_seen = 1;
        if (out_cnt < NB) begin
          check("out_data", out_data, exp_beats[out_cnt]);
          check("out_eol", out_eol, 64'((out_cnt % (W / P)) == (W / P) - 1));
          check("out_eof", out_eof, 64'(out_cnt == NB - 1));
        end
        if (out_eof) check("ctrl_done_with_eof", ctrl_done, 1);
        out_cnt++;
      end else if (first_seen && out_cnt < NB) gaps++;
      if (ctrl_done) begin dones++; done_seen = 1; end
      start = start_mid && in_ready && idx == 6;
      in_valid = 1'b1;
      if (stall_rem > 0 && stall_rem < stall_len && !in_ready) ir_bad++;
      if (in_ready) begin
        if (idx == stall_beat && stall_rem > 0) begin
          in_valid = 1'b0;
          stall_rem--;
        end else if (idx < NB) begin
          in_data = in_beats[idx];
          idx++;
        end
      end
      step();
      cyc++;
    end
    start = 1'b0;
    check("frame_completed", 64'(done_seen), 1);
    for (int i = 0; i < 2; i++) begin
      if (out_valid) extra++;
      if (ctrl_done) dones++;
      step();
    end
    check("vsync_cycles", 64'(vs), SD);
    check("hsync_cycles", 64'(hs), HD * H);
    check("beats_in", 64'(idx), NB);
    check("beats_out", 64'(out_cnt), NB);
    check("extra_out", 64'(extra), 0);
    check("out_gaps", 64'(gaps), 64'(HD + stall_len));
    check("ctrl_done_count", 64'(dones), 1);
    check("underflow_cnt", underflow_cnt, 64'(stall_len));
    check("markers_without_valid", 64'(bad_marks), 0);
    check("in_ready_during_stall", 64'(ir_bad), 0);
    $display("frame %0d: mode=%0d beats_out=%0d underflow_cnt=%0d cycles=%0d", frame_id, m, out_cnt, underflow_cnt, cyc);
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 8'd0,   8'd0,   {24'h010203, 24'hC80AFF}, {24'h010203, 24'hC80AFF}};
    vecs[1] = '{2'b01, 1'b1, 8'd100, 8'd0,   {24'h000000, 24'hC80AFF}, {24'h646464, 24'hFF6EFF}};
    vecs[2] = '{2'b01, 1'b0, 8'd100, 8'd0,   {24'h646563, 24'hC80AFF}, {24'h000100, 24'h64009B}};
    vecs[3] = '{2'b10, 1'b0, 8'd0,   8'd0,   {24'h123456, 24'h0080FF}, {24'hEDCBA9, 24'hFF7F00}};
    vecs[4] = '{2'b11, 1'b0, 8'd0,   8'd90,  {24'h5A5A5A, 24'h5B5A5A}, {24'h000000, 24'hFFFFFF}};
    vecs[5] = '{2'b11, 1'b0, 8'd0,   8'd0,   {24'h000001, 24'h000000}, {24'hFFFFFF, 24'h000000}};
    vecs[6] = '{2'b11, 1'b0, 8'd0,   8'd255, {24'hFFFFFE, 24'hFFFFFF}, {24'h000000, 24'h000000}};
    vecs[7] = '{2'b01, 1'b0, 8'd255, 8'd0,   {24'h000000, 24'hFF0007}, {24'h000000, 24'h000000}};
    vecs[8] = '{2'b01, 1'b1, 8'd255, 8'd0,   {24'h000000, 24'h000102}, {24'hFFFFFF, 24'hFFFFFF}};

    HRESET = 1'b0;
    repeat (3) step();
    check_all_zero("reset_state");
    HRESET = 1'b1;
    step();

    fill_distinct(8'h00);
    run_frame(2'b00, 1'b0, 8'd0, 8'd0, -1, 0, 1'b0);

    for (int v = 0; v < 9; v++) begin
      for (int k = 0; k < NB; k++) begin
        in_beats[k]  = vecs[v].din;
        exp_beats[k] = vecs[v].dexp;
      end
      run_frame(vecs[v].mode, vecs[v].sign, vecs[v].bright, vecs[v].thresh, -1, 0, 1'b0);
    end

    fill_distinct(8'h20);
    run_frame(2'b00, 1'b0, 8'd0, 8'd0, 2, 5, 1'b1);

    // Abort a frame in its second line with a non-zero underflow count, then recover.
    begin
      int acc, cyc, holes;
      acc = 0; cyc = 0; holes = 0;
      frame_id++;
      start = 1'b1; mode = 2'b10;
      step();
      start = 1'b0;
      while (acc < 5 && cyc < 100) begin
        in_valid = 1'b1;
        if (in_ready) begin
          if (holes < 2) begin in_valid = 1'b0; holes++; end
          else begin in_data = {48{1'b1}}; acc++; end
        end
        step();
        cyc++;
      end
      check("abort_reached_line1", 64'(acc), 5);
      check("abort_underflow_before", underflow_cnt, 2);
      HRESET = 1'b0;
      #1;
      check_all_zero("reset_async");
      for (int i = 0; i < 2; i++) begin
        step();
        check_all_zero("reset_hold");
      end
      HRESET = 1'b1;
      for (int i = 0; i < 3; i++) begin
        step();
        check("post_reset_idle", {VSYNC, HSYNC, in_ready, out_valid, ctrl_done}, 0);
      end
      $display("frame %0d: aborted by reset after %0d beats", frame_id, acc);
    end

    fill_distinct(8'h80);
    run_frame(2'b00, 1'b0, 8'd0, 8'd0, -1, 0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
